// File: rtl/aes_package.sv
// Shared AES constants and the inverse key-schedule state type.
// The S-box table is common to the cipher and the key schedules.
package aes_package;

   localparam int DATA_WIDTH = 128;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      READY  = 2'd2
   } inv_ks_state_t;

   // Round constants, index 1..10 used; the rest pad to a 4-bit index.
   localparam logic [7:0] RCON [16] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
// Byte order follows FIPS-197 (bits 31:24 are byte 0).
module aes_sub_word
   import aes_package::*;
(
   input  logic [31:0] w_i,
   output logic [31:0] w_o
);

   // Byte-wise substitution through the shared table
   always_comb begin
      w_o = {SBOX[w_i[31:24]], SBOX[w_i[23:16]],
             SBOX[w_i[15:8]],  SBOX[w_i[7:0]]};
   end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 key schedule producing round keys 10 down to 0.
// Expands forward to K10, then inverts one expansion step per request.
module aes_inv_key_schedule
   import aes_package::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  key_load,
   input  logic [DATA_WIDTH-1:0] key,
   input  logic                  next_req,
   output logic [DATA_WIDTH-1:0] round_key,
   output logic [3:0]            round_idx,
   output logic                  key_ready,
   output logic                  busy
);

   inv_ks_state_t         state_q;
   logic [3:0]            cnt_q;
   logic [DATA_WIDTH-1:0] key_q;
   logic                  busy_q;
   logic                  ready_q;

   logic [31:0] a0, a1, a2, a3;
   logic [31:0] i1, i2, i3;
   logic [31:0] sel_w;
   logic [31:0] sw_in;
   logic [31:0] sw_out;
   logic [31:0] rc_w;
   logic [3:0]  rc_idx;
   logic [31:0] f0, f1, f2, f3;
   logic [DATA_WIDTH-1:0] fwd_d;
   logic [DATA_WIDTH-1:0] inv_d;

   // Split the working key and pick the shared SubWord operand
   always_comb begin
      a0 = key_q[127:96];
      a1 = key_q[95:64];
      a2 = key_q[63:32];
      a3 = key_q[31:0];
      i3 = a3 ^ a2;
      i2 = a2 ^ a1;
      i1 = a1 ^ a0;
      if (state_q == READY) begin
         sel_w  = i3;
         rc_idx = cnt_q;
      end else begin
         sel_w  = a3;
         rc_idx = cnt_q + 4'd1;
      end
      sw_in = {sel_w[23:0], sel_w[31:24]};
      rc_w  = {RCON[rc_idx], 24'h000000};
   end

   aes_sub_word u_sub_word (
      .w_i (sw_in),
      .w_o (sw_out)
   );

   // Forward and inverse single-round steps
   always_comb begin
      f0    = a0 ^ sw_out ^ rc_w;
      f1    = a1 ^ f0;
      f2    = a2 ^ f1;
      f3    = a3 ^ f2;
      fwd_d = {f0, f1, f2, f3};
      inv_d = {f0, i1, i2, i3};
   end

   // Control FSM with counter, working key and registered flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         key_q   <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
      end else if (key_load) begin
         state_q <= EXPAND;
         cnt_q   <= 4'd0;
         key_q   <= key;
         busy_q  <= 1'b1;
         ready_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               busy_q  <= 1'b0;
               ready_q <= 1'b0;
            end
            EXPAND: begin
               key_q <= fwd_d;
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'd9) begin
                  state_q <= READY;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            READY: begin
               if (next_req && cnt_q != 4'd0) begin
                  key_q <= inv_d;
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign round_key = key_q;
   assign round_idx = cnt_q;
   assign key_ready = ready_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for aes_inv_key_schedule: reference expansion model plus
// directed FIPS-197 vectors and per-cycle output comparison.
module tb_aes_inv_key_schedule;

   logic         clk;
   logic         rst;
   logic         key_load;
   logic [127:0] key;
   logic         next_req;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         key_ready;
   logic         busy;

   int n_pass;
   int n_tot;

   localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] A_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] A_K9   = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] C_K10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   aes_inv_key_schedule dut (
      .clk       (clk),
      .rst       (rst),
      .key_load  (key_load),
      .key       (key),
      .next_req  (next_req),
      .round_key (round_key),
      .round_idx (round_idx),
      .key_ready (key_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [7:0] sb [256];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] a, input int n);
      logic [7:0] r;
      r = a;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   // S-box derived from GF(2^8) inverse and the affine map
   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] v;
      for (int i = 0; i < 256; i++) begin
         inv = 8'h00;
         v   = 8'(i);
         if (i != 0)
            for (int j = 1; j < 256; j++)
               if (gmul(v, 8'(j)) == 8'h01) inv = 8'(j);
         sb[i] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3)
                 ^ rl(inv, 4) ^ 8'h63;
      end
   endtask

   // Full forward expansion, returning round key r
   function automatic logic [127:0] rk_of(input logic [127:0] k,
                                          input int r);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]}
                ^ {rc, 24'h000000};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   // Model state: 0 idle, 1 expanding, 2 ready
   int           m_phase;
   int           m_left;
   int           m_idx;
   logic [127:0] m_key;
   bit           m_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase <= 0;
         m_left  <= 0;
         m_idx   <= 0;
         m_valid <= 1'b1;
      end else if (key_load) begin
         m_phase <= 1;
         m_left  <= 10;
         m_key   <= key;
      end else if (m_phase == 1) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_phase <= 2;
            m_idx   <= 10;
         end
      end else if (m_phase == 2 && next_req && m_idx != 0) begin
         m_idx <= m_idx - 1;
      end
   end

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (m_valid) begin
         chk("busy", 128'(busy), 128'(m_phase == 1));
         chk("key_ready", 128'(key_ready), 128'(m_phase == 2));
         if (m_phase == 0) begin
            chk("idle_key", round_key, 128'h0);
            chk("idle_idx", 128'(round_idx), 128'h0);
         end else if (m_phase == 2) begin
            chk("rk", round_key, rk_of(m_key, m_idx));
            chk("idx", 128'(round_idx), 128'(m_idx));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic pulse_load(input logic [127:0] k, input bit req);
      @(negedge clk);
      key_load = 1'b1;
      key      = k;
      next_req = req;
      @(negedge clk);
      key_load = 1'b0;
      next_req = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!key_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic req(input int n);
      @(negedge clk);
      next_req = 1'b1;
      tick(n);
      next_req = 1'b0;
   endtask

   int lat;

   initial begin
      n_pass   = 0;
      n_tot    = 0;
      rst      = 1'b1;
      key_load = 1'b0;
      key      = '0;
      next_req = 1'b0;
      build_sbox();

      chk("model_a_k10", rk_of(KEY_A, 10), A_K10);
      chk("model_a_k9", rk_of(KEY_A, 9), A_K9);
      chk("model_c_k10", rk_of(KEY_C, 10), C_K10);
      chk("model_c_k0", rk_of(KEY_C, 0), KEY_C);

      tick(3);
      rst = 1'b0;
      tick(2);
      chk("reset_key", round_key, 128'h0);
      chk("reset_busy", 128'(busy), 128'h0);
      req(4);
      tick(1);
      chk("idle_req_key", round_key, 128'h0);
      chk("idle_req_rdy", 128'(key_ready), 128'h0);

      pulse_load(KEY_A, 1'b0);
      wait_ready(lat);
      chk("a_latency", 128'(lat), 128'd10);
      chk("a_k10", round_key, A_K10);
      chk("a_idx10", 128'(round_idx), 128'd10);
      req(1);
      chk("a_k9", round_key, A_K9);
      chk("a_idx9", 128'(round_idx), 128'd9);

      pulse_load(KEY_C, 1'b0);
      wait_ready(lat);
      chk("c_latency", 128'(lat), 128'd10);
      chk("c_k10", round_key, C_K10);
      req(10);
      chk("c_k0", round_key, KEY_C);
      chk("c_idx0", 128'(round_idx), 128'd0);
      req(1);
      tick(1);
      chk("c_nowrap_key", round_key, KEY_C);
      chk("c_nowrap_idx", 128'(round_idx), 128'd0);

      pulse_load(KEY_A, 1'b0);
      tick(3);
      pulse_load(KEY_C, 1'b0);
      wait_ready(lat);
      chk("restart_latency", 128'(lat), 128'd10);
      chk("restart_k10", round_key, C_K10);

      req(2);
      pulse_load(KEY_A, 1'b1);
      chk("load_wins_busy", 128'(busy), 128'd1);
      chk("load_wins_rdy", 128'(key_ready), 128'd0);
      wait_ready(lat);
      chk("load_wins_lat", 128'(lat), 128'd10);
      chk("load_wins_k10", round_key, A_K10);

      pulse_load(KEY_A, 1'b0);
      tick(3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rst_exp_key", round_key, 128'h0);
      chk("rst_exp_busy", 128'(busy), 128'h0);
      chk("rst_exp_idx", 128'(round_idx), 128'h0);

      pulse_load(KEY_C, 1'b0);
      wait_ready(lat);
      req(4);
      chk("pre_rst_idx6", 128'(round_idx), 128'd6);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rst_rdy_key", round_key, 128'h0);
      chk("rst_rdy_rdy", 128'(key_ready), 128'h0);
      chk("rst_rdy_idx", 128'(round_idx), 128'h0);

      pulse_load(KEY_A, 1'b0);
      wait_ready(lat);
      chk("post_rst_lat", 128'(lat), 128'd10);
      chk("post_rst_k10", round_key, A_K10);
      req(10);
      chk("post_rst_k0", round_key, KEY_A);
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
